// File: rtl/pbl_pkg.sv
// Constants and state encoding shared by the packing stage of the bottle line.
package pbl_pkg;

  typedef enum logic [1:0] {
    ESPERA_CAIXA = 2'b00,
    ENCHENDO     = 2'b01,
    LIBERANDO    = 2'b10,
    ALARME       = 2'b11
  } estado_t;

  localparam logic [3:0] DUZIA   = 4'd12;
  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/modulo_contador_bcd_2digitos.sv
// Two-digit BCD event counter, 00..99 with silent wrap; shared with the display path.
module modulo_contador_bcd_2digitos
  import pbl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [3:0] dezena,
  output logic [3:0] unidade
);

  logic [3:0] dezena_q, dezena_d;
  logic [3:0] unidade_q, unidade_d;

  always_comb begin
    dezena_d  = dezena_q;
    unidade_d = unidade_q;
    if (inc) begin
      if (unidade_q == BCD_MAX) begin
        unidade_d = '0;
        dezena_d  = (dezena_q == BCD_MAX) ? '0 : dezena_q + 4'd1;
      end else begin
        unidade_d = unidade_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dezena_q  <= '0;
      unidade_q <= '0;
    end else begin
      dezena_q  <= dezena_d;
      unidade_q <= unidade_d;
    end
  end

  assign dezena  = dezena_q;
  assign unidade = unidade_q;

endmodule

// File: rtl/modulo_encaixotador_duzias.sv
// Packing stage: loads sealed bottles into boxes of a dozen, handshakes the box
// conveyor, counts completed boxes in BCD and flags bottles arriving with no box.
module modulo_encaixotador_duzias
  import pbl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       garrafa_vedada,
  input  logic       caixa_presente,
  input  logic       caixa_liberada,
  output logic       esteira_caixa,
  output logic       caixa_cheia,
  output logic       al_caixa,
  output logic [3:0] garrafas_na_caixa,
  output logic [3:0] caixas_dezena,
  output logic [3:0] caixas_unidade,
  output logic [1:0] estado
);

  estado_t    estado_q, estado_d;
  logic [3:0] garrafas_q, garrafas_d;
  logic       g_r_q;
  logic       ev;
  logic       inc_caixa;

  // Edge register tracks the input even while frozen, so a level held across
  // an enable toggle never produces a late event.
  always_ff @(posedge clk) begin
    if (reset) g_r_q <= 1'b0;
    else       g_r_q <= garrafa_vedada;
  end

  assign ev = garrafa_vedada & ~g_r_q;

  always_comb begin
    estado_d   = estado_q;
    garrafas_d = garrafas_q;
    inc_caixa  = 1'b0;
    unique case (estado_q)
      ESPERA_CAIXA: if (enable) begin
        if (caixa_presente) begin
          estado_d = ENCHENDO;
          if (ev) garrafas_d = garrafas_q + 4'd1;
        end else if (ev) begin
          estado_d = ALARME;
        end
      end
      ENCHENDO: if (enable) begin
        if (!caixa_presente) begin
          estado_d = ALARME;
        end else if (ev) begin
          garrafas_d = garrafas_q + 4'd1;
          if (garrafas_q == DUZIA - 4'd1) begin
            estado_d  = LIBERANDO;
            inc_caixa = 1'b1;
          end
        end
      end
      LIBERANDO: if (enable) begin
        if (ev) begin
          estado_d = ALARME;
        end else if (caixa_liberada && !caixa_presente) begin
          estado_d   = ESPERA_CAIXA;
          garrafas_d = '0;
        end
      end
      ALARME: if (!enable) begin
        estado_d   = ESPERA_CAIXA;
        garrafas_d = '0;
      end
      default: estado_d = ESPERA_CAIXA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= ESPERA_CAIXA;
      garrafas_q <= '0;
    end else begin
      estado_q   <= estado_d;
      garrafas_q <= garrafas_d;
    end
  end

  modulo_contador_bcd_2digitos u_contador_caixas (
    .clk     (clk),
    .reset   (reset),
    .inc     (inc_caixa),
    .dezena  (caixas_dezena),
    .unidade (caixas_unidade)
  );

  assign esteira_caixa     = enable & ((estado_q == ESPERA_CAIXA) | (estado_q == LIBERANDO));
  assign caixa_cheia       = (estado_q == LIBERANDO);
  assign al_caixa          = (estado_q == ALARME);
  assign garrafas_na_caixa = garrafas_q;
  assign estado            = estado_q;

endmodule

// File: tb/tb_modulo_encaixotador_duzias.sv
// Directed bench for the dozen-box packing stage.
module tb_modulo_encaixotador_duzias;

  logic       clk = 1'b0;
  logic       reset, enable, garrafa_vedada, caixa_presente, caixa_liberada;
  logic       esteira_caixa, caixa_cheia, al_caixa;
  logic [3:0] garrafas_na_caixa, caixas_dezena, caixas_unidade;
  logic [1:0] estado;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  modulo_encaixotador_duzias dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .garrafa_vedada    (garrafa_vedada),
    .caixa_presente    (caixa_presente),
    .caixa_liberada    (caixa_liberada),
    .esteira_caixa     (esteira_caixa),
    .caixa_cheia       (caixa_cheia),
    .al_caixa          (al_caixa),
    .garrafas_na_caixa (garrafas_na_caixa),
    .caixas_dezena     (caixas_dezena),
    .caixas_unidade    (caixas_unidade),
    .estado            (estado)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulso();
    garrafa_vedada = 1'b1;
    tick();
    garrafa_vedada = 1'b0;
    tick();
  endtask

  task automatic encher_caixa();
    caixa_presente = 1'b1;
    tick();
    repeat (12) pulso();
  endtask

  task automatic liberar();
    caixa_presente = 1'b0;
    caixa_liberada = 1'b1;
    tick();
    caixa_liberada = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; garrafa_vedada = 1'b0;
    caixa_presente = 1'b0; caixa_liberada = 1'b0;
    tick();
    reset = 1'b0;
    chk("rst_estado", {6'd0, estado}, 8'h00);
    chk("rst_garrafas", {4'd0, garrafas_na_caixa}, 8'h00);
    chk("rst_caixas", {caixas_dezena, caixas_unidade}, 8'h00);
    chk("rst_flags", {6'd0, caixa_cheia, al_caixa}, 8'h00);
    chk("rst_esteira", {7'd0, esteira_caixa}, 8'h01);

    // Normal box
    caixa_presente = 1'b1;
    tick();
    chk("enchendo", {6'd0, estado}, 8'h01);
    chk("enchendo_esteira", {7'd0, esteira_caixa}, 8'h00);
    for (int i = 1; i <= 12; i++) begin
      garrafa_vedada = 1'b1;
      tick();
      chk($sformatf("garrafa_%0d", i), {4'd0, garrafas_na_caixa}, 8'(i));
      if (i == 11) chk("caixas_antes_12", {caixas_dezena, caixas_unidade}, 8'h00);
      garrafa_vedada = 1'b0;
      tick();
    end
    chk("cheia_estado", {6'd0, estado}, 8'h02);
    chk("cheia_flag", {7'd0, caixa_cheia}, 8'h01);
    chk("cheia_caixas", {caixas_dezena, caixas_unidade}, 8'h01);
    liberar();
    chk("liberada_estado", {6'd0, estado}, 8'h00);
    chk("liberada_garrafas", {4'd0, garrafas_na_caixa}, 8'h00);
    chk("liberada_esteira", {7'd0, esteira_caixa}, 8'h01);

    // Missing box
    garrafa_vedada = 1'b1;
    tick();
    chk("sem_caixa_estado", {6'd0, estado}, 8'h03);
    chk("sem_caixa_alarme", {7'd0, al_caixa}, 8'h01);
    chk("sem_caixa_esteira", {7'd0, esteira_caixa}, 8'h00);
    garrafa_vedada = 1'b0;
    tick();
    chk("alarme_retido", {6'd0, estado}, 8'h03);
    enable = 1'b0;
    tick();
    chk("alarme_saida_estado", {6'd0, estado}, 8'h00);
    chk("alarme_saida_garrafas", {4'd0, garrafas_na_caixa}, 8'h00);
    chk("alarme_saida_caixas", {caixas_dezena, caixas_unidade}, 8'h01);
    enable = 1'b1;

    // Bottle together with box arrival
    caixa_presente = 1'b1; garrafa_vedada = 1'b1;
    tick();
    chk("simult_espera_estado", {6'd0, estado}, 8'h01);
    chk("simult_espera_garrafas", {4'd0, garrafas_na_caixa}, 8'h01);
    garrafa_vedada = 1'b0;
    tick();

    // Level held high counts once
    garrafa_vedada = 1'b1;
    repeat (20) tick();
    chk("nivel_mantido", {4'd0, garrafas_na_caixa}, 8'h02);
    garrafa_vedada = 1'b0;
    tick();

    // Freeze mid-fill
    repeat (3) pulso();
    chk("pre_freeze", {4'd0, garrafas_na_caixa}, 8'h05);
    enable = 1'b0;
    repeat (3) pulso();
    chk("freeze_garrafas", {4'd0, garrafas_na_caixa}, 8'h05);
    chk("freeze_estado", {6'd0, estado}, 8'h01);
    enable = 1'b1;
    tick();
    chk("pos_freeze", {4'd0, garrafas_na_caixa}, 8'h05);

    // Stale release ignored while filling
    caixa_liberada = 1'b1;
    tick();
    chk("liberada_espuria", {6'd0, estado}, 8'h01);
    caixa_liberada = 1'b0;

    // Box removed together with a bottle: alarm wins, bottle not counted
    garrafa_vedada = 1'b1; caixa_presente = 1'b0;
    tick();
    chk("simult_enchendo_estado", {6'd0, estado}, 8'h03);
    chk("simult_enchendo_garrafas", {4'd0, garrafas_na_caixa}, 8'h05);
    garrafa_vedada = 1'b0; enable = 1'b0;
    tick();
    enable = 1'b1;
    chk("rearme", {4'd0, garrafas_na_caixa}, 8'h00);

    // BCD carry and wrap
    repeat (8) begin encher_caixa(); liberar(); end
    chk("caixas_09", {caixas_dezena, caixas_unidade}, 8'h09);
    encher_caixa(); liberar();
    chk("caixas_10", {caixas_dezena, caixas_unidade}, 8'h10);
    repeat (89) begin encher_caixa(); liberar(); end
    chk("caixas_99", {caixas_dezena, caixas_unidade}, 8'h99);
    encher_caixa(); liberar();
    chk("caixas_wrap_00", {caixas_dezena, caixas_unidade}, 8'h00);

    // Reset in LIBERANDO with 37 boxes
    repeat (36) begin encher_caixa(); liberar(); end
    encher_caixa();
    chk("pre_reset_estado", {6'd0, estado}, 8'h02);
    chk("pre_reset_caixas", {caixas_dezena, caixas_unidade}, 8'h37);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_estado", {6'd0, estado}, 8'h00);
    chk("reset_garrafas", {4'd0, garrafas_na_caixa}, 8'h00);
    chk("reset_caixas", {caixas_dezena, caixas_unidade}, 8'h00);
    chk("reset_flags", {6'd0, caixa_cheia, al_caixa}, 8'h00);
    chk("reset_esteira", {7'd0, esteira_caixa}, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
